// File: rtl/riscv_rf_pkg.sv
// Shared constants, types and sizing helpers for the RI5CY multi-port register file.
package riscv_rf_pkg;

  localparam int NUM_INT_WORDS = 32;
  localparam int NUM_FP_WORDS  = 32;

  typedef logic [5:0] rf_addr_t;

  // A separate FP bank exists only with an FPU that does not share the X bank.
  function automatic int rf_tot_words(input int fpu, input int zfinx);
    return ((fpu == 1) && (zfinx == 0)) ? (NUM_INT_WORDS + NUM_FP_WORDS) : NUM_INT_WORDS;
  endfunction

endpackage

// File: rtl/riscv_rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered population count.
module riscv_rf_scoreboard
  import riscv_rf_pkg::*;
#(
  parameter int ADDR_WIDTH    = 6,
  parameter int NUM_TOT_WORDS = 32,
  parameter int CNT_W         = $clog2(NUM_TOT_WORDS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bset_i,
  input  logic [ADDR_WIDTH-1:0]    bset_addr_i,
  input  logic [NUM_TOT_WORDS-1:0] wr_hit_i,
  output logic [NUM_TOT_WORDS-1:0] busy_o,
  output logic [CNT_W-1:0]         busy_cnt_o
);

  localparam int IDX_W = $clog2(NUM_TOT_WORDS);

  logic [NUM_TOT_WORDS-1:0] busy_q, busy_d, bset_hit;
  logic [CNT_W-1:0]         cnt_q, cnt_d, clr_cnt;
  logic [IDX_W-1:0]         bset_idx;
  logic                     unused_addr;

  assign bset_idx    = bset_addr_i[IDX_W-1:0];
  assign unused_addr = ^bset_addr_i;

  // A bset overrides a same-cycle write to the same register; x0 never becomes busy.
  always_comb begin
    bset_hit = '0;
    if (bset_i && (bset_idx != '0)) begin
      bset_hit[bset_idx] = 1'b1;
    end
    busy_d    = bset_hit | (busy_q & ~wr_hit_i);
    busy_d[0] = 1'b0;
    clr_cnt   = '0;
    for (int r = 0; r < NUM_TOT_WORDS; r++) begin
      if (busy_q[r] && !busy_d[r]) begin
        clr_cnt = clr_cnt + CNT_W'(1);
      end
    end
    cnt_d = cnt_q + CNT_W'(|(bset_hit & ~busy_q)) - clr_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/riscv_register_file_mp.sv
// Parametrised multi-port RI5CY register file with optional FP bank and pending-write scoreboard.
// Define RF_BYPASS_EN to forward same-cycle winning writes to the read ports.
module riscv_register_file_mp
  import riscv_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RPORTS = 3,
  parameter int NUM_WPORTS = 2,
  parameter int FPU        = 0,
  parameter int ZFINX      = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 test_en_i,
  input  logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0] raddr_i,
  output logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0] rdata_o,
  output logic [NUM_RPORTS-1:0]                 rbusy_o,
  input  logic [NUM_WPORTS-1:0][ADDR_WIDTH-1:0] waddr_i,
  input  logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_WPORTS-1:0]                 we_i,
  input  logic                                 bset_i,
  input  logic [ADDR_WIDTH-1:0]                 bset_addr_i,
  output logic [$clog2(rf_tot_words(FPU, ZFINX)+1)-1:0] busy_cnt_o
);

  localparam int NUM_TOT_WORDS = rf_tot_words(FPU, ZFINX);
  localparam int IDX_W         = $clog2(NUM_TOT_WORDS);

  typedef logic [IDX_W-1:0] idx_t;

  logic [DATA_WIDTH-1:0]    mem_q [NUM_TOT_WORDS];
  logic [DATA_WIDTH-1:0]    mem_d [NUM_TOT_WORDS];
  logic [NUM_TOT_WORDS-1:0] wr_hit;
  logic [NUM_TOT_WORDS-1:0] busy;
  idx_t                     rd_idx [NUM_RPORTS];
  logic                     unused_inputs;

  assign unused_inputs = ^{test_en_i, raddr_i, waddr_i};

  // Ports are scanned in ascending order so the highest-index enabled port wins.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NUM_TOT_WORDS; r++) begin
      mem_d[r] = mem_q[r];
    end
    mem_d[0] = '0;
    for (int r = 1; r < NUM_TOT_WORDS; r++) begin
      for (int p = 0; p < NUM_WPORTS; p++) begin
        if (we_i[p] && (waddr_i[p][IDX_W-1:0] == idx_t'(r))) begin
          wr_hit[r] = 1'b1;
          mem_d[r]  = wdata_i[p];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_TOT_WORDS; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  riscv_rf_scoreboard #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .NUM_TOT_WORDS (NUM_TOT_WORDS)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .bset_i      (bset_i),
    .bset_addr_i (bset_addr_i),
    .wr_hit_i    (wr_hit),
    .busy_o      (busy),
    .busy_cnt_o  (busy_cnt_o)
  );

  always_comb begin
    for (int i = 0; i < NUM_RPORTS; i++) begin
      rd_idx[i] = raddr_i[i][IDX_W-1:0];
    end
  end

  // Without an FP bank the upper address bit is dropped, aliasing f-addresses onto the X bank.
  always_comb begin
    for (int i = 0; i < NUM_RPORTS; i++) begin
      rdata_o[i] = mem_q[rd_idx[i]];
      rbusy_o[i] = busy[rd_idx[i]];
`ifdef RF_BYPASS_EN
      if ((rd_idx[i] != '0) && wr_hit[rd_idx[i]]) begin
        rdata_o[i] = mem_d[rd_idx[i]];
        rbusy_o[i] = bset_i && (bset_addr_i[IDX_W-1:0] == rd_idx[i]);
      end
`endif
    end
  end

endmodule

// File: tb/tb_riscv_register_file_mp.sv
// Self-checking bench for riscv_register_file_mp: a default X-only instance and an FP-bank instance
// driven in lockstep and compared every cycle against an array-based behavioural model.
module tb_riscv_register_file_mp;
  import riscv_rf_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rf_addr_t [2:0]   raddr;
  rf_addr_t [1:0]   waddr;
  logic [1:0][31:0] wdata;
  logic [1:0]       we;
  logic             bset;
  rf_addr_t         bset_addr;

  logic [2:0][31:0] rdata_a, rdata_b;
  logic [2:0]       rbusy_a, rbusy_b;
  logic [5:0]       busy_cnt_a;
  logic [6:0]       busy_cnt_b;

  int compared   = 0;
  int mismatched = 0;
  bit check_en   = 1'b0;

  logic [31:0] m_reg  [2][64];
  bit          m_busy [2][64];

  always #5 clk = ~clk;

  riscv_register_file_mp u_dut_x (
    .clk         (clk),
    .rst_n       (rst_n),
    .test_en_i   (1'b0),
    .raddr_i     (raddr),
    .rdata_o     (rdata_a),
    .rbusy_o     (rbusy_a),
    .waddr_i     (waddr),
    .wdata_i     (wdata),
    .we_i        (we),
    .bset_i      (bset),
    .bset_addr_i (bset_addr),
    .busy_cnt_o  (busy_cnt_a)
  );

  riscv_register_file_mp #(.FPU(1), .ZFINX(0)) u_dut_fp (
    .clk         (clk),
    .rst_n       (rst_n),
    .test_en_i   (1'b0),
    .raddr_i     (raddr),
    .rdata_o     (rdata_b),
    .rbusy_o     (rbusy_b),
    .waddr_i     (waddr),
    .wdata_i     (wdata),
    .we_i        (we),
    .bset_i      (bset),
    .bset_addr_i (bset_addr),
    .busy_cnt_o  (busy_cnt_b)
  );

  // Model instance 0 has 32 registers (address bit 5 ignored), instance 1 has 64.
  function automatic int midx(input int k, input rf_addr_t a);
    return (k == 1) ? int'(a) : int'(a[4:0]);
  endfunction

  function automatic logic [31:0] expData(input int k, input rf_addr_t a);
    int r;
    logic [31:0] d;
    r = midx(k, a);
    d = m_reg[k][r];
`ifdef RF_BYPASS_EN
    for (int p = 0; p < 2; p++) begin
      if (r != 0 && we[p] && midx(k, waddr[p]) == r) d = wdata[p];
    end
`endif
    return d;
  endfunction

  function automatic logic [31:0] expBusy(input int k, input rf_addr_t a);
    int r;
    bit b;
    r = midx(k, a);
    b = m_busy[k][r];
`ifdef RF_BYPASS_EN
    for (int p = 0; p < 2; p++) begin
      if (r != 0 && we[p] && midx(k, waddr[p]) == r) b = bset && (midx(k, bset_addr) == r);
    end
`endif
    return {31'b0, b};
  endfunction

  function automatic logic [31:0] expCnt(input int k);
    int n;
    n = 0;
    for (int r = 0; r < 64; r++) n += int'(m_busy[k][r]);
    return 32'(n);
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 64; r++) begin
        m_reg[k][r]  = '0;
        m_busy[k][r] = 1'b0;
      end
    end
  endtask

  task automatic modelStep();
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (we[p]) begin
          int r;
          r = midx(k, waddr[p]);
          if (r != 0) begin
            m_reg[k][r]  = wdata[p];
            m_busy[k][r] = 1'b0;
          end
        end
      end
      if (bset) begin
        int r;
        r = midx(k, bset_addr);
        if (r != 0) m_busy[k][r] = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("rdata_x[%0d]", i), rdata_a[i], expData(0, raddr[i]));
        checkOutput($sformatf("rbusy_x[%0d]", i), {31'b0, rbusy_a[i]}, expBusy(0, raddr[i]));
        checkOutput($sformatf("rdata_fp[%0d]", i), rdata_b[i], expData(1, raddr[i]));
        checkOutput($sformatf("rbusy_fp[%0d]", i), {31'b0, rbusy_b[i]}, expBusy(1, raddr[i]));
      end
      checkOutput("busy_cnt_x", 32'(busy_cnt_a), expCnt(0));
      checkOutput("busy_cnt_fp", 32'(busy_cnt_b), expCnt(1));
    end
  end

  task automatic clearInputs();
    raddr     = '0;
    waddr     = '0;
    wdata     = '0;
    we        = '0;
    bset      = 1'b0;
    bset_addr = '0;
  endtask

  task automatic setWrite(input int p, input rf_addr_t a, input logic [31:0] d);
    we[p]    = 1'b1;
    waddr[p] = a;
    wdata[p] = d;
  endtask

  task automatic setBset(input rf_addr_t a);
    bset      = 1'b1;
    bset_addr = a;
  endtask

  // Move to the sampling point of the current cycle (just after the falling edge).
  task automatic applyStimulus();
    @(negedge clk);
    #1;
  endtask

  task automatic endCycle();
    @(posedge clk);
    modelStep();
    #1;
    clearInputs();
  endtask

  task automatic runCycle();
    applyStimulus();
    endCycle();
  endtask

  initial begin
    clearInputs();
    modelReset();
    #7;
    rst_n    = 1'b1;
    check_en = 1'b1;

    // Every address on every port reads zero and idle after reset.
    for (int a = 0; a < 64; a++) begin
      for (int i = 0; i < 3; i++) raddr[i] = rf_addr_t'((a + 21 * i) % 64);
      applyStimulus();
      if (a == 0) begin
        checkOutput("reset_rdata", rdata_a[0], 32'h0);
        checkOutput("reset_rbusy", {31'b0, rbusy_a[0]}, 32'h0);
        checkOutput("reset_cnt", 32'(busy_cnt_a), 32'h0);
      end
      endCycle();
    end

    setWrite(0, 6'd5, 32'hAAAA0000);
    setWrite(1, 6'd5, 32'h5555FFFF);
    runCycle();
    raddr[0] = 6'd5;
    applyStimulus();
    checkOutput("x5_priority", rdata_a[0], 32'h5555FFFF);
    checkOutput("x5_priority_fp", rdata_b[0], 32'h5555FFFF);
    endCycle();

    setWrite(0, 6'd0, 32'hDEADBEEF);
    runCycle();
    setBset(6'd0);
    runCycle();
    raddr[0] = 6'd0;
    applyStimulus();
    checkOutput("x0_zero", rdata_a[0], 32'h0);
    checkOutput("x0_not_busy_cnt", 32'(busy_cnt_a), 32'h0);
    endCycle();

    setBset(6'd10);
    runCycle();
    for (int c = 0; c < 3; c++) begin
      raddr[0] = 6'd10;
      applyStimulus();
      checkOutput("x10_busy", {31'b0, rbusy_a[0]}, 32'h1);
      checkOutput("x10_cnt_one", 32'(busy_cnt_a), 32'h1);
      endCycle();
    end
    setWrite(1, 6'd10, 32'h1234);
    raddr[0] = 6'd10;
    runCycle();
    raddr[0] = 6'd10;
    applyStimulus();
    checkOutput("x10_data", rdata_a[0], 32'h1234);
    checkOutput("x10_idle", {31'b0, rbusy_a[0]}, 32'h0);
    checkOutput("x10_cnt_zero", 32'(busy_cnt_a), 32'h0);
    endCycle();

    setWrite(0, 6'd33, 32'h3F800000);
    setWrite(1, 6'd1, 32'h7);
    runCycle();
    raddr[0] = 6'd33;
    raddr[1] = 6'd1;
    applyStimulus();
    checkOutput("f1_fp", rdata_b[0], 32'h3F800000);
    checkOutput("x1_fp", rdata_b[1], 32'h7);
    checkOutput("f1_alias", rdata_a[0], 32'h7);
    checkOutput("x1_alias", rdata_a[1], 32'h7);
    endCycle();
    setWrite(0, 6'd33, 32'hCAFE);
    runCycle();
    raddr[0] = 6'd1;
    applyStimulus();
    checkOutput("alias_write", rdata_a[0], 32'hCAFE);
    checkOutput("fp_bank_isolated", rdata_b[0], 32'h7);
    endCycle();

    setWrite(0, 6'd7, 32'h11);
    runCycle();
    setWrite(0, 6'd7, 32'h99);
    raddr[2] = 6'd7;
    applyStimulus();
`ifdef RF_BYPASS_EN
    checkOutput("bypass_same_cycle", rdata_a[2], 32'h99);
`else
    checkOutput("bypass_same_cycle", rdata_a[2], 32'h11);
`endif
    endCycle();
    raddr[2] = 6'd7;
    applyStimulus();
    checkOutput("x7_next_cycle", rdata_a[2], 32'h99);
    endCycle();

    // Several clears in one cycle, repeated bset, and bset colliding with a write.
    for (int a = 2; a <= 4; a++) begin
      setBset(rf_addr_t'(a));
      runCycle();
    end
    setWrite(0, 6'd2, 32'h22);
    setWrite(1, 6'd3, 32'h33);
    setBset(6'd4);
    applyStimulus();
    checkOutput("cnt_three", 32'(busy_cnt_a), 32'h3);
    endCycle();
    setWrite(1, 6'd20, 32'h2020);
    setBset(6'd20);
    applyStimulus();
    checkOutput("cnt_after_double_clear", 32'(busy_cnt_a), 32'h1);
    endCycle();
    raddr[0] = 6'd20;
    applyStimulus();
    checkOutput("bset_wins_data", rdata_a[0], 32'h2020);
    checkOutput("bset_wins_busy", {31'b0, rbusy_a[0]}, 32'h1);
    checkOutput("bset_wins_cnt", 32'(busy_cnt_a), 32'h2);
    endCycle();
    setWrite(0, 6'd20, 32'h0);
    setWrite(1, 6'd4, 32'h44);
    runCycle();
    applyStimulus();
    checkOutput("cnt_cleared", 32'(busy_cnt_a), 32'h0);
    endCycle();

    for (int a = 1; a < 64; a++) begin
      setBset(rf_addr_t'(a));
      runCycle();
    end
    applyStimulus();
    checkOutput("cnt_max_x", 32'(busy_cnt_a), 32'd31);
    checkOutput("cnt_max_fp", 32'(busy_cnt_b), 32'd63);
    endCycle();

    // Asynchronous reset between edges clears data and pending bits at once.
    #1;
    rst_n = 1'b0;
    modelReset();
    #1;
    raddr[0] = 6'd5;
    raddr[1] = 6'd10;
    #1;
    checkOutput("async_rst_data", rdata_a[0], 32'h0);
    checkOutput("async_rst_busy", {31'b0, rbusy_a[1]}, 32'h0);
    checkOutput("async_rst_cnt_x", 32'(busy_cnt_a), 32'h0);
    checkOutput("async_rst_cnt_fp", 32'(busy_cnt_b), 32'h0);
    rst_n = 1'b1;

    setWrite(0, 6'd10, 32'hBEEF);
    runCycle();
    raddr[0] = 6'd10;
    applyStimulus();
    checkOutput("late_wb_data", rdata_a[0], 32'hBEEF);
    checkOutput("late_wb_busy", {31'b0, rbusy_a[0]}, 32'h0);
    checkOutput("late_wb_cnt", 32'(busy_cnt_a), 32'h0);
    endCycle();

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/riscv_register_file_mp.md
# riscv_register_file_mp

Parametrised multi-port register file for the RI5CY core, successor to the fixed 3-read/2-write flip-flop file. Read and write port counts are configurable, and the optional FP bank is kept. Adds a per-register pending-write scoreboard for long-latency producers (LSU, FPU, divider), with a busy count for stall and debug logic. Sits in the ID stage; the scoreboard replaces ad-hoc hazard tracking in the controller.

## Interface
- ADDR_WIDTH, 6, register address width; bit 5 selects the FP bank when present
- DATA_WIDTH, 32, register width
- NUM_RPORTS, 3, number of read ports (1..4)
- NUM_WPORTS, 2, number of write ports (1..3); a higher index has higher priority
- FPU, 0, 1 = FP bank present
- ZFINX, 0, 1 = FP operands live in the X bank; no FP bank is built
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- test_en_i  in  1  test mode; no functional effect, kept for compatibility
- raddr_i  in  NUM_RPORTS x ADDR_WIDTH  read addresses
- rdata_o  out  NUM_RPORTS x DATA_WIDTH  read data
- rbusy_o  out  NUM_RPORTS  addressed register has a pending write
- waddr_i  in  NUM_WPORTS x ADDR_WIDTH  write addresses
- wdata_i  in  NUM_WPORTS x DATA_WIDTH  write data
- we_i  in  NUM_WPORTS  write enables
- bset_i  in  1  mark a register pending; issued with a long-latency op
- bset_addr_i  in  ADDR_WIDTH  address to mark
- busy_cnt_o  out  $clog2(NUM_TOT_WORDS+1)  number of registers currently pending

## Operation
- NUM_TOT_WORDS: 32 when FPU=0 or ZFINX=1; otherwise 64. FP bank occupies addresses 32..63.
- Without an FP bank, address bit 5 is ignored on both reads and writes, so addresses alias to the X bank.
- x0 (address 0) always reads 0 and is never written. It is never busy: a bset to address 0 is ignored.
- FP register f0 (address 32) is an ordinary, writable register.
- Write arbitration: for each register, the highest-index port with we_i high and a matching address writes. All other ports are dropped for that register in that cycle.
- Scoreboard, one busy bit per register:
  - Set by bset_i.
  - Cleared by any write that lands on the register.
  - Simultaneous bset and write to the same register: bset wins, the bit stays 1, and the data write still happens.
- busy_cnt_o equals the population count of the busy bits, held in a registered counter.
  - Per-cycle update: +1 for a set of a not-yet-busy register, −1 for each cleared register.
  - Net changes of −NUM_WPORTS..+1 per cycle must be handled.
  - The counter never wraps. Its maximum value is NUM_TOT_WORDS−1, because x0 is excluded.
- Reset values: all registers 0, all busy bits 0, busy_cnt_o 0, so rbusy_o=0 and rdata_o=0.
- Reset asserted mid-operation clears all state immediately (asynchronous), including pending bits. Late writebacks arriving after reset write data normally; no busy bits are affected.

## Timing
- Reads are combinational from the storage flops.
- Writes and busy updates take effect at the clock edge. Without the bypass, a written value is visible from the next cycle.
- rbusy_o is combinational from the busy bits. A bset in cycle N gives rbusy_o=1 from cycle N+1.
- busy_cnt_o is registered and updates in the same edge as the busy bits.

## Configuration
- RF_BYPASS_EN defined:
  - A read whose address matches a same-cycle winning write returns wdata_i of that write.
  - rbusy_o for that read is forced to 0, unless a bset to the same address occurs in the same cycle.
  - Bypass to x0 is never applied.
- RF_BYPASS_EN undefined: reads return only stored values, and rbusy_o reflects only the stored busy bits.

## Structure
- Shared package riscv_rf_pkg:
  - constants NUM_INT_WORDS=32 and NUM_FP_WORDS=32
  - function rf_tot_words(FPU, ZFINX)
  - address typedef rf_addr_t
- Sub-module riscv_rf_scoreboard: owns the busy bits and busy_cnt_o.
  - Inputs: bset_i, bset_addr_i, and the decoded per-register write hits.
  - The top level keeps storage, arbitration, read muxes and the bypass.

## Test plan
- Reset, then read every address on all ports -> rdata_o=0, rbusy_o=0, busy_cnt_o=0.
- Ports 0 and 1 write address 5 with 0xAAAA0000 and 0x5555FFFF in the same cycle -> next cycle x5 reads 0x5555FFFF.
- Write 0xDEADBEEF to address 0, then bset address 0 -> x0 reads 0, busy_cnt_o stays 0.
- bset address 10, then after 3 idle cycles write 10=0x1234 -> rbusy_o=1 for 3 cycles, busy_cnt_o goes 1 then 0, x10 reads 0x1234.
- FPU=1, ZFINX=0: write 0x3F800000 to address 33 and 0x7 to address 1 -> the two banks are distinct. With FPU=0, address 33 aliases to x1.
- With RF_BYPASS_EN: in the same cycle, write 7=0x99 and read address 7 -> rdata_o=0x99. Without the macro -> the old value that cycle, 0x99 the next.
